// File: rtl/rx_deser.sv
// Serial-to-parallel receiver: idle-high line, start bit, 8 data bits LSB first,
// optional even parity, stop bit. Words appear on Pout with a one-cycle valid pulse.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | line idle, watching the synchronised line for a start bit
// START      | timing the start bit, rejecting glitches at the sample point
// DATA       | sampling 8 data bits, LSB first
// PARITY     | sampling the even-parity bit (only when PARITY_EN)
// STOP       | checking stop bit and parity at mid-bit, then leaving early
// WAIT_IDLE  | framing error or break: hold until the line returns high
module rx_deser #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       resetN,
  input  logic       Sin,
  output logic [7:0] Pout,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] SAMPLE = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic             r_par;
  logic [7:0]       r_pout;
  logic             r_valid;
  logic             r_err;

  logic w_s;
  logic w_sample;
  logic w_wrap;
  logic w_par_ok;

  assign w_s      = r_sync2;
  assign w_sample = (r_cnt == SAMPLE);
  assign w_wrap   = (r_cnt == LAST);
  assign w_par_ok = !PARITY_EN || ((^r_shift ^ r_par) == 1'b0);

  always_ff @(posedge CLOCK_50) begin
    if (!resetN) begin
      r_state <= ST_IDLE;
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_pout  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_sync1 <= Sin;
      r_sync2 <= r_sync1;
      r_valid <= 1'b0;
      r_err   <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (!w_s) r_state <= ST_START;
        end

        ST_START: begin
          // glitch rejection takes priority over the wrap when CLKS_PER_BIT==1
          if (w_sample && w_s) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (w_wrap) begin
            r_state <= ST_DATA;
            r_cnt   <= '0;
            r_idx   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (w_sample) r_shift[r_idx] <= w_s;
          if (w_wrap) begin
            r_cnt <= '0;
            if (r_idx == 3'd7) r_state <= PARITY_EN ? ST_PARITY : ST_STOP;
            else               r_idx   <= r_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_PARITY: begin
          if (w_sample) r_par <= w_s;
          if (w_wrap) begin
            r_cnt   <= '0;
            r_state <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          // leave at mid-bit so a start bit right after the stop bit is caught
          if (w_sample) begin
            r_cnt <= '0;
            if (w_s) begin
              r_state <= ST_IDLE;
              if (w_par_ok) begin
                r_valid <= 1'b1;
                r_pout  <= r_shift;
              end else begin
                r_err <= 1'b1;
              end
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_WAIT_IDLE: begin
          r_cnt <= '0;
          if (w_s) r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign Pout  = r_pout;
  assign valid = r_valid;
  assign err   = r_err;
  assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rx_deser.sv
// Directed bench for rx_deser: frames are built bit by bit here and the
// valid/err pulses are collected by a negedge monitor.
module tb_rx_deser;

  localparam int CPB = 4;
  localparam bit PEN = 1'b1;

  logic       clk;
  logic       resetN;
  logic       Sin;
  logic [7:0] Pout;
  logic       valid;
  logic       err;
  logic       busy;

  int checks;
  int errors;

  int         vcount;
  int         ecount;
  int         both;
  logic [7:0] vq[$];

  rx_deser #(.CLKS_PER_BIT(CPB), .PARITY_EN(PEN)) dut (
    .CLOCK_50 (clk),
    .resetN   (resetN),
    .Sin      (Sin),
    .Pout     (Pout),
    .valid    (valid),
    .err      (err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (valid) begin
      vcount++;
      vq.push_back(Pout);
    end
    if (err) ecount++;
    if (valid && err) both++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    Sin = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_inv, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PEN) send_bit((^d) ^ par_inv);
    send_bit(stop_b);
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    Sin    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++;
      if (Pout !== 8'h00) begin errors++; $display("FAIL reset_pout cyc%0d got %h exp 00", i, Pout); end
      checks++;
      if ({valid, err, busy} !== 3'b000) begin
        errors++; $display("FAIL reset_flags cyc%0d got v/e/b=%b exp 000", i, {valid, err, busy});
      end
    end
    resetN = 1'b1;
    tick(2);
  endtask

  task automatic test_single();
    int v0, e0;
    v0 = vcount; e0 = ecount;
    send_frame(8'hA5, 1'b0, 1'b1);
    tick(8);
    checks++;
    if (vcount - v0 !== 1) begin errors++; $display("FAIL single_valid got %0d pulses exp 1", vcount - v0); end
    checks++;
    if (Pout !== 8'hA5) begin errors++; $display("FAIL single_pout got %h exp a5", Pout); end
    checks++;
    if (ecount - e0 !== 0) begin errors++; $display("FAIL single_err got %0d pulses exp 0", ecount - e0); end
  endtask

  task automatic test_back_to_back();
    int v0, e0;
    logic [7:0] exp_w [3];
    exp_w[0] = 8'h00; exp_w[1] = 8'hFF; exp_w[2] = 8'h3C;
    v0 = vcount; e0 = ecount;
    for (int i = 0; i < 3; i++) send_frame(exp_w[i], 1'b0, 1'b1);
    tick(8);
    checks++;
    if (vcount - v0 !== 3) begin errors++; $display("FAIL b2b_count got %0d pulses exp 3", vcount - v0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (v0 + i >= vq.size()) begin
        errors++; $display("FAIL b2b_word%0d missing exp %h", i, exp_w[i]);
      end else if (vq[v0 + i] !== exp_w[i]) begin
        errors++; $display("FAIL b2b_word%0d got %h exp %h", i, vq[v0 + i], exp_w[i]);
      end
    end
    checks++;
    if (ecount - e0 !== 0) begin errors++; $display("FAIL b2b_err got %0d pulses exp 0", ecount - e0); end
  endtask

  task automatic test_parity_error();
    int v0, e0;
    v0 = vcount; e0 = ecount;
    send_frame(8'h01, 1'b1, 1'b1);
    tick(8);
    checks++;
    if (ecount - e0 !== 1) begin errors++; $display("FAIL parity_err got %0d pulses exp 1", ecount - e0); end
    checks++;
    if (vcount - v0 !== 0) begin errors++; $display("FAIL parity_valid got %0d pulses exp 0", vcount - v0); end
    checks++;
    if (Pout !== 8'h3C) begin errors++; $display("FAIL parity_pout got %h exp 3c", Pout); end
  endtask

  task automatic test_framing_break();
    int v0, e0;
    v0 = vcount; e0 = ecount;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(logic'((8'h55 >> i) & 8'h01));
    send_bit(1'b0);
    Sin = 1'b0;
    tick(CPB + 20);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL break_busy got %b exp 1", busy); end
    checks++;
    if (ecount - e0 !== 1) begin errors++; $display("FAIL break_err got %0d pulses exp 1", ecount - e0); end
    checks++;
    if (vcount - v0 !== 0) begin errors++; $display("FAIL break_valid got %0d pulses exp 0", vcount - v0); end
    Sin = 1'b1;
    tick(4);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL break_release got busy %b exp 0", busy); end
    v0 = vcount;
    send_frame(8'h12, 1'b0, 1'b1);
    tick(8);
    checks++;
    if (vcount - v0 !== 1) begin errors++; $display("FAIL after_break_valid got %0d pulses exp 1", vcount - v0); end
    checks++;
    if (Pout !== 8'h12) begin errors++; $display("FAIL after_break_pout got %h exp 12", Pout); end
  endtask

  task automatic test_glitch_and_reset();
    int v0, e0;
    v0 = vcount; e0 = ecount;
    Sin = 1'b0;
    tick(1);
    Sin = 1'b1;
    tick(8);
    checks++;
    if ((vcount - v0 !== 0) || (ecount - e0 !== 0)) begin
      errors++; $display("FAIL glitch_pulses got v=%0d e=%0d exp 0 0", vcount - v0, ecount - e0);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b exp 0", busy); end
    checks++;
    if (Pout !== 8'h12) begin errors++; $display("FAIL glitch_pout got %h exp 12", Pout); end

    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    resetN = 1'b0;
    Sin    = 1'b1;
    tick(1);
    checks++;
    if ({Pout, valid, err, busy} !== 11'b0) begin
      errors++; $display("FAIL mid_reset got pout=%h v/e/b=%b exp 00 000", Pout, {valid, err, busy});
    end
    tick(1);
    resetN = 1'b1;
    tick(6);
    checks++;
    if ((vcount - v0 !== 0) || (ecount - e0 !== 0)) begin
      errors++; $display("FAIL mid_reset_pulses got v=%0d e=%0d exp 0 0", vcount - v0, ecount - e0);
    end
    send_frame(8'h9C, 1'b0, 1'b1);
    tick(8);
    checks++;
    if (vcount - v0 !== 1) begin errors++; $display("FAIL post_reset_valid got %0d pulses exp 1", vcount - v0); end
    checks++;
    if (Pout !== 8'h9C) begin errors++; $display("FAIL post_reset_pout got %h exp 9c", Pout); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vcount = 0;
    ecount = 0;
    both   = 0;
    resetN = 1'b0;
    Sin    = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_parity_error();
    test_framing_break();
    test_glitch_and_reset();
    checks++;
    if (both !== 0) begin errors++; $display("FAIL valid_err_overlap got %0d cycles exp 0", both); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
